rv_pipe_ctrl: RTL and testbench

- Control unit for the 5-stage pipelined RV32I core; successor to the single-cycle combinational decoder.
- Decodes the ID-stage instruction into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers.
- Resolves branches and jumps in EX, detects data hazards, and drives stall, flush and forwarding selects.
- Parametrised for forwarding on/off, register address width and counter width; adds saturating stall and flush performance counters.

---
 rtl/rv_pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_rv_pipe_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_pipe_ctrl.sv
// rv_pipe_ctrl: pipelined RV32I control unit (decode, ID/EX/MEM/WB control bundle, hazards, forwarding, perf counters)
//   clk, rst_n              clock, asynchronous active-low reset
//   id_instr, id_valid      instruction in ID and its valid flag
//   ex_br_eq, ex_br_lt      EX-stage comparator results
//   pc_stall, ifid_stall    hold PC / IF/ID on a data hazard
//   ifid_flush              bubble into IF/ID on a taken branch or jump
//   id_imm_sel, id_illegal  ID immediate format and illegal-opcode flag
//   ex_*                    EX controls: ALU op/select, operand selects, branch, forwarding
//   mem_mem_rw, mem_wb_sel  MEM controls
//   wb_reg_we, wb_wb_sel, wb_rd  WB controls
//   stall_cnt, flush_cnt    saturating stall / flush cycle counters
module rv_pipe_ctrl #(
    parameter int FWD_EN = 1,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       id_instr,
    input  logic              id_valid,
    input  logic              ex_br_eq,
    input  logic              ex_br_lt,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic [2:0]        id_imm_sel,
    output logic              id_illegal,
    output logic [2:0]        ex_alu_op,
    output logic [2:0]        ex_alu_sel,
    output logic              ex_a_sel,
    output logic              ex_b_sel,
    output logic              ex_br_un,
    output logic              ex_pc_sel,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic              mem_mem_rw,
    output logic [1:0]        mem_wb_sel,
    output logic              wb_reg_we,
    output logic [1:0]        wb_wb_sel,
    output logic [REG_AW-1:0] wb_rd,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    typedef struct packed {
        logic              reg_we;
        logic              mem_rw;
        logic [1:0]        wb_sel;
        logic [2:0]        alu_op;
        logic [2:0]        alu_sel;
        logic              a_sel;
        logic              b_sel;
        logic              br;
        logic              jmp;
        logic              ld;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } ctrl_t;
    logic [6:0]        op;
    logic [2:0]        f3;
    logic              is_r, is_i, is_l, is_s, is_b, is_jalr, is_jal, is_lui, is_auipc, legal;
    logic              unused_bits;
    ctrl_t             dec, ex;
    logic              mem_we, mem_ld;
    logic [REG_AW-1:0] mem_rd;
    logic              br_take, ex_hit, mem_hit, hazard, stall, id_go;
    assign op       = id_instr[6:0];
    assign f3       = id_instr[14:12];
    assign is_r     = op == 7'b0110011;
    assign is_i     = op == 7'b0010011;
    assign is_l     = op == 7'b0000011;
    assign is_s     = op == 7'b0100011;
    assign is_b     = op == 7'b1100011;
    assign is_jalr  = op == 7'b1100111;
    assign is_jal   = op == 7'b1101111;
    assign is_lui   = op == 7'b0110111;
    assign is_auipc = op == 7'b0010111;
    assign legal    = is_r | is_i | is_l | is_s | is_b | is_jalr | is_jal | is_lui | is_auipc;
    // funct7 bits other than bit 30 do not affect control
    assign unused_bits = ^{id_instr[31], id_instr[29:25]};
    assign id_illegal = id_valid & ~legal;
    assign id_imm_sel = !id_valid ? 3'd0 :
                        (is_i | is_l | is_jalr) ? 3'd1 :
                        is_s ? 3'd2 :
                        is_b ? 3'd3 :
                        is_jal ? 3'd4 :
                        (is_lui | is_auipc) ? 3'd5 : 3'd0;
    // Unused source fields are zeroed so hazard and forward compares need no per-type qualification
    always_comb begin
        dec         = '0;
        dec.reg_we  = (is_r | is_i | is_l | is_jalr | is_jal | is_lui | is_auipc) && id_instr[7 +: REG_AW] != '0;
        dec.mem_rw  = is_s;
        dec.wb_sel  = is_l ? 2'd0 : (is_jal | is_jalr) ? 2'd2 : 2'd1;
        dec.alu_op  = f3;
        dec.alu_sel = (is_l | is_s | is_b | is_jal | is_jalr | is_auipc) ? 3'd4 :
                      is_lui ? 3'd3 :
                      ((is_r || (is_i && f3 == 3'b101)) && id_instr[30]) ? 3'd1 : 3'd0;
        dec.a_sel   = is_b | is_jal | is_auipc;
        dec.b_sel   = legal & ~is_r;
        dec.br      = is_b;
        dec.jmp     = is_jal | is_jalr;
        dec.ld      = is_l;
        dec.rd      = id_instr[7 +: REG_AW];
        dec.rs1     = (is_r | is_i | is_l | is_s | is_b | is_jalr) ? id_instr[15 +: REG_AW] : '0;
        dec.rs2     = (is_r | is_s | is_b) ? id_instr[20 +: REG_AW] : '0;
    end
    // funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 01x never taken
    assign br_take   = ex.alu_op[2] ? (ex.alu_op[0] ? ~ex_br_lt : ex_br_lt) :
                       ex.alu_op[1] ? 1'b0 : (ex.alu_op[0] ? ~ex_br_eq : ex_br_eq);
    assign ex_pc_sel = ex.jmp | (ex.br & br_take);
    assign ex_br_un  = ex.br & ex.alu_op[1];
    // reg_we implies rd != 0, so a zeroed (unused) source can never match
    assign ex_hit  = ex.reg_we && (ex.rd == dec.rs1 || ex.rd == dec.rs2);
    assign mem_hit = mem_we && (mem_rd == dec.rs1 || mem_rd == dec.rs2);
    assign hazard  = (FWD_EN != 0) ? (ex_hit && ex.ld) : (ex_hit || mem_hit);
    // A redirect makes the ID instruction wrong-path, so it never stalls
    assign stall      = id_valid && hazard && !ex_pc_sel;
    assign pc_stall   = stall;
    assign ifid_stall = stall;
    assign ifid_flush = ex_pc_sel;
    assign id_go      = id_valid && legal && !stall && !ex_pc_sel;
    assign ex_alu_op  = ex.alu_op;
    assign ex_alu_sel = ex.alu_sel;
    assign ex_a_sel   = ex.a_sel;
    assign ex_b_sel   = ex.b_sel;
    assign ex_fwd_a = (FWD_EN == 0 || ex.rs1 == '0) ? 2'd0 :
                      (mem_we && !mem_ld && mem_rd == ex.rs1) ? 2'd1 :
                      (wb_reg_we && wb_rd == ex.rs1) ? 2'd2 : 2'd0;
    assign ex_fwd_b = (FWD_EN == 0 || ex.rs2 == '0) ? 2'd0 :
                      (mem_we && !mem_ld && mem_rd == ex.rs2) ? 2'd1 :
                      (wb_reg_we && wb_rd == ex.rs2) ? 2'd2 : 2'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex         <= '0;
            mem_we     <= 1'b0;
            mem_ld     <= 1'b0;
            mem_rd     <= '0;
            mem_mem_rw <= 1'b0;
            mem_wb_sel <= 2'd0;
            wb_reg_we  <= 1'b0;
            wb_wb_sel  <= 2'd0;
            wb_rd      <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            ex         <= id_go ? dec : '0;
            mem_we     <= ex.reg_we;
            mem_ld     <= ex.ld;
            mem_rd     <= ex.rd;
            mem_mem_rw <= ex.mem_rw;
            mem_wb_sel <= ex.wb_sel;
            wb_reg_we  <= mem_we;
            wb_wb_sel  <= mem_wb_sel;
            wb_rd      <= mem_rd;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (ex_pc_sel && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// tb_rv_pipe_ctrl: directed bench; instance a uses forwarding, instance b interlocks with 3-bit counters
module tb_rv_pipe_ctrl;
    localparam logic [31:0] ADD_5_1_2  = 32'h002082B3;
    localparam logic [31:0] SUB_6_5_3  = 32'h40328333;
    localparam logic [31:0] LW_5_1     = 32'h0000A283;
    localparam logic [31:0] ADD_6_5_5  = 32'h00528333;
    localparam logic [31:0] BEQ_9_9    = 32'h00948663;
    localparam logic [31:0] BLTU_1_2   = 32'h0020E463;
    localparam logic [31:0] ADDI_7_0   = 32'h00100393;
    localparam logic [31:0] ADD_8_7_7  = 32'h00738433;
    localparam logic [31:0] ADD_0_1_2  = 32'h00208033;
    localparam logic [31:0] SW_5_1     = 32'h0050A023;
    localparam logic [31:0] JAL_1      = 32'h000000EF;
    localparam logic [31:0] ILLEGAL    = 32'h0000007F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_instr = '0, b_instr = '0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        br_eq = 1'b0, br_lt = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        a_pc_stall, a_ifid_stall, a_ifid_flush, a_id_illegal, a_ex_a_sel, a_ex_b_sel, a_ex_br_un, a_ex_pc_sel;
    logic        a_mem_mem_rw, a_wb_reg_we;
    logic [2:0]  a_id_imm_sel, a_ex_alu_op, a_ex_alu_sel;
    logic [1:0]  a_ex_fwd_a, a_ex_fwd_b, a_mem_wb_sel, a_wb_wb_sel;
    logic [4:0]  a_wb_rd;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_stall, b_ifid_stall, b_ifid_flush, b_id_illegal, b_ex_a_sel, b_ex_b_sel, b_ex_br_un, b_ex_pc_sel;
    logic        b_mem_mem_rw, b_wb_reg_we;
    logic [2:0]  b_id_imm_sel, b_ex_alu_op, b_ex_alu_sel;
    logic [1:0]  b_ex_fwd_a, b_ex_fwd_b, b_mem_wb_sel, b_wb_wb_sel;
    logic [4:0]  b_wb_rd;
    logic [2:0]  b_stall_cnt, b_flush_cnt;
    logic [63:0] a_all;
    logic [37:0] b_all;

    assign a_all = {a_pc_stall, a_ifid_stall, a_ifid_flush, a_id_imm_sel, a_id_illegal, a_ex_alu_op, a_ex_alu_sel,
                    a_ex_a_sel, a_ex_b_sel, a_ex_br_un, a_ex_pc_sel, a_ex_fwd_a, a_ex_fwd_b, a_mem_mem_rw,
                    a_mem_wb_sel, a_wb_reg_we, a_wb_wb_sel, a_wb_rd, a_stall_cnt, a_flush_cnt};
    assign b_all = {b_pc_stall, b_ifid_stall, b_ifid_flush, b_id_imm_sel, b_id_illegal, b_ex_alu_op, b_ex_alu_sel,
                    b_ex_a_sel, b_ex_b_sel, b_ex_br_un, b_ex_pc_sel, b_ex_fwd_a, b_ex_fwd_b, b_mem_mem_rw,
                    b_mem_wb_sel, b_wb_reg_we, b_wb_wb_sel, b_wb_rd, b_stall_cnt, b_flush_cnt};

    always #5 clk = ~clk;

    rv_pipe_ctrl #(.FWD_EN(1), .REG_AW(5), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_instr(a_instr), .id_valid(a_valid), .ex_br_eq(br_eq), .ex_br_lt(br_lt),
        .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall), .ifid_flush(a_ifid_flush), .id_imm_sel(a_id_imm_sel),
        .id_illegal(a_id_illegal), .ex_alu_op(a_ex_alu_op), .ex_alu_sel(a_ex_alu_sel), .ex_a_sel(a_ex_a_sel),
        .ex_b_sel(a_ex_b_sel), .ex_br_un(a_ex_br_un), .ex_pc_sel(a_ex_pc_sel), .ex_fwd_a(a_ex_fwd_a),
        .ex_fwd_b(a_ex_fwd_b), .mem_mem_rw(a_mem_mem_rw), .mem_wb_sel(a_mem_wb_sel), .wb_reg_we(a_wb_reg_we),
        .wb_wb_sel(a_wb_wb_sel), .wb_rd(a_wb_rd), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    rv_pipe_ctrl #(.FWD_EN(0), .REG_AW(5), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_instr(b_instr), .id_valid(b_valid), .ex_br_eq(br_eq), .ex_br_lt(br_lt),
        .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall), .ifid_flush(b_ifid_flush), .id_imm_sel(b_id_imm_sel),
        .id_illegal(b_id_illegal), .ex_alu_op(b_ex_alu_op), .ex_alu_sel(b_ex_alu_sel), .ex_a_sel(b_ex_a_sel),
        .ex_b_sel(b_ex_b_sel), .ex_br_un(b_ex_br_un), .ex_pc_sel(b_ex_pc_sel), .ex_fwd_a(b_ex_fwd_a),
        .ex_fwd_b(b_ex_fwd_b), .mem_mem_rw(b_mem_mem_rw), .mem_wb_sel(b_mem_wb_sel), .wb_reg_we(b_wb_reg_we),
        .wb_wb_sel(b_wb_wb_sel), .wb_rd(b_wb_rd), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (a_all !== '0) begin errors++; $display("FAIL reset_a got %h exp 0", a_all); end
        checks++;
        if (b_all !== '0) begin errors++; $display("FAIL reset_b got %h exp 0", b_all); end
        rst_n = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (a_all !== '0) begin errors++; $display("FAIL reset_release got %h exp 0", a_all); end
        step();
    endtask

    task automatic test_forward();
        a_valid = 1'b1;
        a_instr = ADD_5_1_2;
        @(negedge clk);
        checks++;
        if ({a_id_imm_sel, a_id_illegal} !== {3'd0, 1'b0}) begin errors++; $display("FAIL fwd_id_add got %h exp 0", {a_id_imm_sel, a_id_illegal}); end
        step();
        a_instr = SUB_6_5_3;
        @(negedge clk);
        checks++;
        if ({a_pc_stall, a_ifid_stall} !== 2'b00) begin errors++; $display("FAIL fwd_no_stall got %b exp 00", {a_pc_stall, a_ifid_stall}); end
        step();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_ex_fwd_a, a_ex_fwd_b, a_ex_alu_sel, a_ex_b_sel} !== {2'd1, 2'd0, 3'd1, 1'b0}) begin
            errors++; $display("FAIL fwd_sub_ex got fa=%0d fb=%0d sel=%0d b=%0d exp 1 0 1 0", a_ex_fwd_a, a_ex_fwd_b, a_ex_alu_sel, a_ex_b_sel);
        end
        step();
        @(negedge clk);
        checks++;
        if ({a_wb_reg_we, a_wb_wb_sel, a_wb_rd, a_mem_wb_sel, a_mem_mem_rw} !== {1'b1, 2'd1, 5'd5, 2'd1, 1'b0}) begin
            errors++; $display("FAIL fwd_add_wb got we=%b sel=%0d rd=%0d msel=%0d exp 1 1 5 1", a_wb_reg_we, a_wb_wb_sel, a_wb_rd, a_mem_wb_sel);
        end
        drain();
    endtask

    task automatic test_load_use();
        a_valid = 1'b1;
        a_instr = LW_5_1;
        @(negedge clk);
        checks++;
        if (a_id_imm_sel !== 3'd1) begin errors++; $display("FAIL lu_imm_sel got %0d exp 1", a_id_imm_sel); end
        step();
        a_instr = ADD_6_5_5;
        @(negedge clk);
        checks++;
        if ({a_pc_stall, a_ifid_stall, a_ifid_flush} !== 3'b110) begin errors++; $display("FAIL lu_stall got %b exp 110", {a_pc_stall, a_ifid_stall, a_ifid_flush}); end
        step();
        @(negedge clk);
        checks++;
        if ({a_pc_stall, a_ex_alu_sel, a_ex_b_sel} !== {1'b0, 3'd0, 1'b0}) begin
            errors++; $display("FAIL lu_one_cycle got stall=%b sel=%0d b=%b exp 0 0 0", a_pc_stall, a_ex_alu_sel, a_ex_b_sel);
        end
        step();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_ex_fwd_a, a_ex_fwd_b} !== {2'd2, 2'd2}) begin errors++; $display("FAIL lu_fwd got %0d %0d exp 2 2", a_ex_fwd_a, a_ex_fwd_b); end
        checks++;
        if ({a_wb_reg_we, a_wb_wb_sel, a_wb_rd} !== {1'b1, 2'd0, 5'd5}) begin
            errors++; $display("FAIL lu_wb got we=%b sel=%0d rd=%0d exp 1 0 5", a_wb_reg_we, a_wb_wb_sel, a_wb_rd);
        end
        checks++;
        if (a_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", a_stall_cnt); end
        drain();
    endtask

    task automatic test_branch();
        a_valid = 1'b1;
        a_instr = BEQ_9_9;
        br_eq = 1'b1;
        @(negedge clk);
        checks++;
        if (a_id_imm_sel !== 3'd3) begin errors++; $display("FAIL br_imm_sel got %0d exp 3", a_id_imm_sel); end
        step();
        a_instr = ADD_5_1_2;
        @(negedge clk);
        checks++;
        if ({a_ex_pc_sel, a_ifid_flush, a_pc_stall, a_ex_a_sel, a_ex_b_sel, a_ex_alu_sel, a_ex_br_un} !== {5'b11011, 3'd4, 1'b0}) begin
            errors++; $display("FAIL beq_taken got pc=%b fl=%b st=%b a=%b b=%b sel=%0d un=%b exp 1 1 0 1 1 4 0",
                a_ex_pc_sel, a_ifid_flush, a_pc_stall, a_ex_a_sel, a_ex_b_sel, a_ex_alu_sel, a_ex_br_un);
        end
        step();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_ex_pc_sel, a_ifid_flush, a_ex_alu_sel, a_ex_a_sel, a_ex_b_sel} !== 7'd0) begin
            errors++; $display("FAIL beq_bubble got pc=%b fl=%b sel=%0d a=%b b=%b exp all 0", a_ex_pc_sel, a_ifid_flush, a_ex_alu_sel, a_ex_a_sel, a_ex_b_sel);
        end
        checks++;
        if (a_flush_cnt !== 16'd1) begin errors++; $display("FAIL beq_flush_cnt got %0d exp 1", a_flush_cnt); end
        drain();
        br_eq = 1'b0;
        a_valid = 1'b1;
        a_instr = BEQ_9_9;
        step();
        a_instr = SUB_6_5_3;
        @(negedge clk);
        checks++;
        if ({a_ex_pc_sel, a_ifid_flush} !== 2'b00) begin errors++; $display("FAIL beq_not_taken got %b exp 00", {a_ex_pc_sel, a_ifid_flush}); end
        step();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_ex_alu_sel !== 3'd1) begin errors++; $display("FAIL beq_fallthrough got sel=%0d exp 1", a_ex_alu_sel); end
        drain();
        a_valid = 1'b1;
        a_instr = BLTU_1_2;
        br_lt = 1'b1;
        step();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_ex_pc_sel, a_ex_br_un, a_ex_alu_op} !== {1'b1, 1'b1, 3'd6}) begin
            errors++; $display("FAIL bltu got pc=%b un=%b op=%0d exp 1 1 6", a_ex_pc_sel, a_ex_br_un, a_ex_alu_op);
        end
        step();
        br_lt = 1'b0;
        @(negedge clk);
        checks++;
        if (a_flush_cnt !== 16'd2) begin errors++; $display("FAIL bltu_flush_cnt got %0d exp 2", a_flush_cnt); end
        drain();
    endtask

    task automatic test_illegal();
        a_valid = 1'b0;
        a_instr = ILLEGAL;
        @(negedge clk);
        checks++;
        if (a_id_illegal !== 1'b0) begin errors++; $display("FAIL illegal_invalid got %b exp 0", a_id_illegal); end
        a_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_id_illegal, a_id_imm_sel} !== {1'b1, 3'd0}) begin errors++; $display("FAIL illegal_flag got %b/%0d exp 1/0", a_id_illegal, a_id_imm_sel); end
        step();
        a_instr = ADD_0_1_2;
        @(negedge clk);
        checks++;
        if ({a_id_illegal, a_ex_b_sel, a_ex_alu_sel} !== 5'd0) begin
            errors++; $display("FAIL illegal_bubble got ill=%b b=%b sel=%0d exp 0 0 0", a_id_illegal, a_ex_b_sel, a_ex_alu_sel);
        end
        step();
        a_valid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if ({a_wb_reg_we, a_wb_wb_sel} !== {1'b0, 2'd0}) begin errors++; $display("FAIL illegal_wb got we=%b sel=%0d exp 0 0", a_wb_reg_we, a_wb_wb_sel); end
        step();
        @(negedge clk);
        checks++;
        if ({a_wb_reg_we, a_wb_wb_sel} !== {1'b0, 2'd1}) begin errors++; $display("FAIL x0_write_wb got we=%b sel=%0d exp 0 1", a_wb_reg_we, a_wb_wb_sel); end
        drain();
    endtask

    task automatic test_no_forward();
        b_valid = 1'b1;
        b_instr = ADDI_7_0;
        step();
        b_instr = ADD_8_7_7;
        @(negedge clk);
        checks++;
        if ({b_pc_stall, b_ifid_stall, b_ex_fwd_a, b_ex_fwd_b} !== 6'b110000) begin
            errors++; $display("FAIL nofwd_stall1 got st=%b%b fa=%0d fb=%0d exp 11 0 0", b_pc_stall, b_ifid_stall, b_ex_fwd_a, b_ex_fwd_b);
        end
        step();
        @(negedge clk);
        checks++;
        if ({b_pc_stall, b_ifid_stall} !== 2'b11) begin errors++; $display("FAIL nofwd_stall2 got %b exp 11", {b_pc_stall, b_ifid_stall}); end
        step();
        @(negedge clk);
        checks++;
        if (b_pc_stall !== 1'b0) begin errors++; $display("FAIL nofwd_release got %b exp 0", b_pc_stall); end
        step();
        b_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({b_ex_fwd_a, b_ex_fwd_b, b_ex_b_sel, b_stall_cnt} !== {2'd0, 2'd0, 1'b0, 3'd2}) begin
            errors++; $display("FAIL nofwd_ex got fa=%0d fb=%0d cnt=%0d exp 0 0 2", b_ex_fwd_a, b_ex_fwd_b, b_stall_cnt);
        end
        drain();
    endtask

    task automatic test_flush_over_stall();
        b_valid = 1'b1;
        b_instr = JAL_1;
        @(negedge clk);
        checks++;
        if (b_id_imm_sel !== 3'd4) begin errors++; $display("FAIL jal_imm_sel got %0d exp 4", b_id_imm_sel); end
        step();
        b_instr = ADD_5_1_2;
        @(negedge clk);
        checks++;
        if ({b_ex_pc_sel, b_ifid_flush, b_pc_stall, b_ifid_stall} !== 4'b1100) begin
            errors++; $display("FAIL flush_wins got %b exp 1100", {b_ex_pc_sel, b_ifid_flush, b_pc_stall, b_ifid_stall});
        end
        step();
        b_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({b_ex_pc_sel, b_stall_cnt, b_flush_cnt, b_mem_wb_sel} !== {1'b0, 3'd2, 3'd1, 2'd2}) begin
            errors++; $display("FAIL flush_after got pc=%b st=%0d fl=%0d msel=%0d exp 0 2 1 2", b_ex_pc_sel, b_stall_cnt, b_flush_cnt, b_mem_wb_sel);
        end
        drain();
    endtask

    task automatic test_saturate();
        for (int r = 0; r < 4; r++) begin
            b_valid = 1'b1;
            b_instr = ADDI_7_0;
            step();
            b_instr = ADD_8_7_7;
            repeat (3) step();
            drain();
            if (r == 0) begin
                @(negedge clk);
                checks++;
                if (b_stall_cnt !== 3'd4) begin errors++; $display("FAIL sat_stall_mid got %0d exp 4", b_stall_cnt); end
            end
        end
        @(negedge clk);
        checks++;
        if (b_stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_stall got %0d exp 7", b_stall_cnt); end
        b_valid = 1'b1;
        b_instr = JAL_1;
        repeat (16) step();
        drain();
        @(negedge clk);
        checks++;
        if ({b_flush_cnt, b_stall_cnt} !== {3'd7, 3'd7}) begin errors++; $display("FAIL sat_flush got fl=%0d st=%0d exp 7 7", b_flush_cnt, b_stall_cnt); end
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1;
        a_instr = SW_5_1;
        step();
        a_valid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if ({a_mem_mem_rw, a_wb_reg_we} !== 2'b10) begin errors++; $display("FAIL store_in_mem got %b exp 10", {a_mem_mem_rw, a_wb_reg_we}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_mem_mem_rw, a_stall_cnt, a_flush_cnt} !== 33'd0) begin
            errors++; $display("FAIL async_reset got rw=%b st=%0d fl=%0d exp 0", a_mem_mem_rw, a_stall_cnt, a_flush_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (a_all !== '0) begin errors++; $display("FAIL reset_mid_a got %h exp 0", a_all); end
        checks++;
        if (b_all !== '0) begin errors++; $display("FAIL reset_mid_b got %h exp 0", b_all); end
    endtask

    initial begin
        repeat (2) step();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_illegal();
        test_no_forward();
        test_flush_over_stall();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
